multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencer for the reduced RISC-V core. It replaces the single-cycle control path with a fetch/decode/execute/writeback state machine that drives the PC, register-file and ALU controls. It handles variable-latency instruction memory through a request/valid handshake and exposes run/single-step debug control. It sits between the instruction memory, the PC block and the register/ALU datapath.

## Interface
- CNT_WIDTH, 32, width of retired-instruction counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = free-run instructions back-to-back
- step_req  in  1  pulse; execute exactly one instruction while halted
- step_ack  out  1  one-cycle pulse when a stepped instruction retires
- imem_req  out  1  fetch request, held until accepted
- imem_valid  in  1  fetch data valid; accepted only in FETCH
- imem_rdata  in  32  fetched instruction word
- EQ  in  1  ALU zero/equal flag from datapath
- instr  out  32  instruction register (IR)
- PCWrite  out  1  PC update enable
- PCsrc  out  1  0 = PC+4, 1 = PC+ImmOp
- RegWrite  out  1  register-file write enable
- ALUctrl  out  3  000 add, 001 sub
- ALUsrc  out  1  0 = rs2, 1 = ImmOp
- ImmSrc  out  1  0 = I-type, 1 = B-type
- halted  out  1  state is HALT
- trap  out  1  sticky illegal-instruction flag
- retired  out  CNT_WIDTH  retired-instruction count

## Operation
- Supported instructions:
  - addi: opcode 0010011, funct3 000
  - add: opcode 0110011, funct3 000, funct7 0
  - bne: opcode 1100011, funct3 001
  - Anything else is illegal.
- States: HALT, FETCH, DECODE, EXEC, WB, TRAP.
- HALT: run=1 goes to FETCH with step_mode=0. Otherwise step_req=1 goes to FETCH with step_mode=1. Otherwise stay.
- FETCH: imem_req=1. On imem_valid, IR<=imem_rdata and go to DECODE.
- DECODE: illegal goes to TRAP. Otherwise go to EXEC. ImmSrc is valid from DECODE onward.
- EXEC:
  - addi: ALUsrc=1, ALUctrl=000, go to WB.
  - add: ALUsrc=0, ALUctrl=000, go to WB.
  - bne: ALUsrc=0, ALUctrl=001, PCWrite=1, PCsrc=!EQ, then retire.
- WB: RegWrite=1, PCWrite=1, PCsrc=0, ALU controls held from EXEC, then retire.
- Retire (on the transition out of EXEC for bne, or out of WB):
  - retired increments and wraps modulo 2^CNT_WIDTH.
  - If step_mode=1: step_ack=1 for one cycle, go to HALT.
  - Else if run=1: go to FETCH.
  - Else: go to HALT.
- TRAP: terminal until reset. trap=1, all enables 0, no increment, no step_ack.
- Control outputs are combinational from state and IR. Enables are 0 in every state not listed above.

## Timing
- Reset values: state HALT, IR=0, step_mode=0, retired=0, trap=0.
- Reset outputs: all enables/controls 0, halted=1, step_ack=0, imem_req=0.
- Reset is asynchronous; imem_req drops immediately, including mid-fetch.
- Latency with zero-wait memory (imem_valid in the first FETCH cycle):
  - addi/add: 4 cycles (FETCH, DECODE, EXEC, WB).
  - bne: 3 cycles.
  - Each wait cycle of memory adds one cycle.
- Throughput in free-run: the next FETCH begins the cycle after retire. HALT is not visited.
- run falling mid-instruction: the instruction completes, then HALT.
- run rising during a step: the step still ends in HALT with step_ack.
- step_req outside HALT is ignored. step_req with run=1 in HALT: run wins, no step_ack.
- imem_valid outside FETCH is ignored, and IR is unchanged.
- EQ is sampled only in the bne EXEC cycle.

## Structure
- Shared package cpu_pkg:
  - opcode/funct3/funct7 constants
  - state enum
  - ALUctrl encodings (ALU_ADD=3'b000, ALU_SUB=3'b001)
  - ImmSrc encodings
- Sub-module instr_decode: combinational, IR in; outputs is_addi, is_add, is_bne, illegal, ImmSrc.
- The FSM, IR, step_mode and counter live in multicycle_ctrl.

## Test plan
- Reset, run=1, zero-wait memory, IR=0x00500093 (addi x1,x0,5):
  - WB in cycle 4 with RegWrite=1, PCWrite=1, PCsrc=0, ALUsrc=1.
  - retired=1 after retire.
- bne with EQ=0 (IR=0xFE209EE3): EXEC shows PCWrite=1, PCsrc=1, ALUctrl=001. Repeat with EQ=1: PCsrc=0. Each takes 3 cycles.
- imem_valid delayed 3 cycles: imem_req held 4 cycles, IR captured only on the valid cycle, instruction latency grows by 3.
- run=0, one step_req pulse with add x3,x1,x2: exactly one retire, step_ack pulses once, halted=1 afterwards, retired=1.
- Illegal IR=0xFFFFFFFF: TRAP after DECODE, trap=1 sticky. Further run/step has no effect, and retired is unchanged until rst low.
- rst low mid-FETCH: imem_req=0 asynchronously, all outputs at reset values. Also: preload retired to all-ones, retire one instruction, and check it wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the reduced RISC-V multi-cycle control path:
// instruction fields, ALU/immediate selects and the sequencer state set.
package cpu_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic IMM_I = 1'b0;
  localparam logic IMM_B = 1'b1;

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_TRAP
  } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational decoder for the three supported instructions (addi, add, bne);
// everything else is flagged illegal.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_addi,
  output logic        is_add,
  output logic        is_bne,
  output logic        illegal,
  output logic        ImmSrc
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register specifiers are datapath business; only the class fields matter here.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  assign is_addi = (opcode == OP_IMM) && (funct3 == F3_ADD);
  assign is_add  = (opcode == OP_REG) && (funct3 == F3_ADD) && (funct7 == F7_ADD);
  assign is_bne  = (opcode == OP_BRANCH) && (funct3 == F3_BNE);
  assign illegal = !(is_addi || is_add || is_bne);
  assign ImmSrc  = is_bne ? IMM_B : IMM_I;

endmodule

// File: rtl/multicycle_ctrl.sv
// Fetch/decode/execute/writeback sequencer with variable-latency fetch,
// run/single-step debug control, sticky illegal-instruction trap and retire counter.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step_req,
  output logic                 step_ack,
  output logic                 imem_req,
  input  logic                 imem_valid,
  input  logic [31:0]          imem_rdata,
  input  logic                 EQ,
  output logic [31:0]          instr,
  output logic                 PCWrite,
  output logic                 PCsrc,
  output logic                 RegWrite,
  output logic [2:0]           ALUctrl,
  output logic                 ALUsrc,
  output logic                 ImmSrc,
  output logic                 halted,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] retired
);

  state_e               state_q, state_d;
  logic [31:0]          ir_q, ir_d;
  logic                 step_mode_q, step_mode_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic is_addi, is_add, is_bne, illegal, dec_imm_src;
  logic retire;

  instr_decode u_decode (
    .instr   (ir_q),
    .is_addi (is_addi),
    .is_add  (is_add),
    .is_bne  (is_bne),
    .illegal (illegal),
    .ImmSrc  (dec_imm_src)
  );

  // bne finishes in EXEC; register-writing instructions finish in WB.
  assign retire = ((state_q == S_EXEC) && is_bne) || (state_q == S_WB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HALT;
      ir_q        <= '0;
      step_mode_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      step_mode_q <= step_mode_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    step_mode_d = step_mode_q;
    retired_d   = retired_q;
    unique case (state_q)
      S_HALT: begin
        if (run) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end else if (step_req) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
      S_EXEC:   if (!is_bne) state_d = S_WB;
      S_WB:     state_d = S_WB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_HALT;
    endcase
    // A stepped instruction always parks in HALT, even if run rose meanwhile.
    if (retire) begin
      retired_d = retired_q + 1'b1;
      state_d   = (!step_mode_q && run) ? S_FETCH : S_HALT;
    end
  end

  always_comb begin
    imem_req = 1'b0;
    PCWrite  = 1'b0;
    PCsrc    = 1'b0;
    RegWrite = 1'b0;
    ALUctrl  = ALU_ADD;
    ALUsrc   = 1'b0;
    ImmSrc   = IMM_I;
    step_ack = 1'b0;
    unique case (state_q)
      S_FETCH:  imem_req = 1'b1;
      S_DECODE: ImmSrc = dec_imm_src;
      S_EXEC: begin
        ImmSrc  = dec_imm_src;
        ALUsrc  = is_addi;
        ALUctrl = is_bne ? ALU_SUB : ALU_ADD;
        if (is_bne) begin
          PCWrite  = 1'b1;
          PCsrc    = !EQ;
          step_ack = step_mode_q;
        end
      end
      S_WB: begin
        ImmSrc   = dec_imm_src;
        ALUsrc   = is_addi;
        ALUctrl  = ALU_ADD;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        step_ack = step_mode_q;
      end
      default: ;
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign trap    = (state_q == S_TRAP);
  assign instr   = ir_q;
  assign retired = retired_q;

endmodule
